// File: rtl/uart16550_rx.sv
// -----------------------------------------------------------------------------
// uart16550_rx
//
// Receive half of a 16550-style UART: a 2-flop line synchronizer, a
// programmable 16x oversample tick generator, a start/data/parity/stop frame
// FSM that samples each bit at mid-bit, a receive FIFO with overrun handling,
// sticky line-status flags and a trigger-level data-available interrupt.
//
// Ports
//   wb_clk_i     single clock, all state on its rising edge
//   wb_rst_n_i   asynchronous active-low reset
//   srx_i        asynchronous serial line, idle high
//   divisor_i    clock cycles per 16x tick (0 disables reception)
//   lcr_wlen_i   word length, 0..3 -> 5..8 data bits
//   lcr_pen_i    parity enable
//   lcr_eps_i    even parity select (1 even, 0 odd)
//   fifo_clr_i   synchronous FIFO flush
//   trig_i       interrupt trigger level, 0..3 -> 1/4/8/14 entries
//   rd_i         pop the FIFO head (RBR read)
//   lsr_rd_i     LSR read, clears the sticky flags
//   rx_dat_o     FIFO head byte, 8'h00 when empty
//   dr_o         data ready (FIFO not empty)
//   oe_o/pe_o/fe_o/bi_o  sticky overrun / parity / framing / break
//   fifo_cnt_o   FIFO occupancy
//   rx_irq_o     registered data-available interrupt
// -----------------------------------------------------------------------------
module uart16550_rx #(
  parameter int RX_FIFO_DEPTH = 16,
  parameter int DIV_W         = 16
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_n_i,
  input  logic                             srx_i,
  input  logic [DIV_W-1:0]                 divisor_i,
  input  logic [1:0]                       lcr_wlen_i,
  input  logic                             lcr_pen_i,
  input  logic                             lcr_eps_i,
  input  logic                             fifo_clr_i,
  input  logic [1:0]                       trig_i,
  input  logic                             rd_i,
  input  logic                             lsr_rd_i,
  output logic [7:0]                       rx_dat_o,
  output logic                             dr_o,
  output logic                             oe_o,
  output logic                             pe_o,
  output logic                             fe_o,
  output logic                             bi_o,
  output logic [$clog2(RX_FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                             rx_irq_o
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchronizer (resets to the idle level so reset never looks like a
  // start bit).
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) sync_q <= 2'b11;
    else             sync_q <= {sync_q[0], srx_i};
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // 16x tick generator: one-cycle pulse each time the down-counter hits 0.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q;
  logic             div_zero;
  logic             tick;

  assign div_zero = (divisor_i == '0);
  assign tick     = !div_zero && (div_cnt_q == '0);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)   div_cnt_q <= '0;
    else if (div_zero) div_cnt_q <= '0;
    else if (tick)     div_cnt_q <= divisor_i - DIV_W'(1);
    else               div_cnt_q <= div_cnt_q - DIV_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] tick_cnt_q;     // free-runs mod 16 from START entry
  logic [2:0] bit_cnt_q;
  logic [7:0] shreg_q;
  logic       par_q;
  logic       armed_q;
  logic [1:0] wlen_q;         // word format latched per character
  logic       pen_q;
  logic       eps_q;
  logic       mid;
  logic [2:0] last_bit;
  logic       go_data;
  logic       take_bit;
  logic       take_par;
  logic       take_stop;

  // The tick counter starts at 0 on START entry, so count 7 recurs every 16
  // ticks and lands on the middle of every bit of the frame.
  assign mid      = tick && (tick_cnt_q == 4'd7);
  assign last_bit = 3'(wlen_q) + 3'd4;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    go_data   = 1'b0;
    take_bit  = 1'b0;
    take_par  = 1'b0;
    take_stop = 1'b0;
    if (div_zero) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s && armed_q) state_d = START;
        end
        START: begin
          if (mid) begin
            if (rx_s) begin
              state_d = IDLE;         // false start
            end else begin
              state_d = DATA;
              go_data = 1'b1;
            end
          end
        end
        DATA: begin
          if (mid) begin
            take_bit = 1'b1;
            if (bit_cnt_q == last_bit) state_d = pen_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (mid) begin
            take_par = 1'b1;
            state_d  = STOP;
          end
        end
        STOP: begin
          if (mid) begin
            take_stop = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Character assembled at the stop-bit sample, pushed one cycle later.
  logic       push_q;
  logic [7:0] push_dat_q;
  logic       push_pe_q;
  logic       push_fe_q;
  logic       push_bi_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      armed_q    <= 1'b0;
      wlen_q     <= '0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
      push_pe_q  <= 1'b0;
      push_fe_q  <= 1'b0;
      push_bi_q  <= 1'b0;
    end else begin
      if (state_q == IDLE) tick_cnt_q <= '0;
      else if (tick)       tick_cnt_q <= tick_cnt_q + 4'd1;

      // After a stop sample the line must be seen high again before another
      // start is accepted; this keeps a held-low break from repeating.
      if (take_stop)                     armed_q <= 1'b0;
      else if (state_q == IDLE && rx_s)  armed_q <= 1'b1;

      if (go_data) begin
        wlen_q    <= lcr_wlen_i;
        pen_q     <= lcr_pen_i;
        eps_q     <= lcr_eps_i;
        shreg_q   <= '0;            // unused upper bits stay 0
        bit_cnt_q <= '0;
      end else if (take_bit) begin
        shreg_q[bit_cnt_q] <= rx_s;
        bit_cnt_q          <= bit_cnt_q + 3'd1;
      end

      if (take_par) par_q <= rx_s;

      push_q <= take_stop;
      if (take_stop) begin
        push_dat_q <= shreg_q;
        // even parity wants XOR 0, odd wants XOR 1, i.e. XOR must equal ~eps
        push_pe_q  <= pen_q && ((^shreg_q ^ par_q) != ~eps_q);
        push_fe_q  <= !rx_s;
        push_bi_q  <= !rx_s && (shreg_q == 8'h00) && (!pen_q || !par_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_en;
  logic          wr_en;
  logic          full;
  logic          ovr;
  logic [8:0]    trig_lvl;
  logic          irq_d;

  always_comb begin
    rd_en = rd_i && (cnt_q != '0);
    full  = (cnt_q == CW'(RX_FIFO_DEPTH));
    // A simultaneous read makes room, so a push into a full FIFO still fits.
    wr_en = push_q && !fifo_clr_i && (!full || rd_en);
    ovr   = push_q && !fifo_clr_i && full && !rd_en;

    cnt_d = cnt_q;
    if (fifo_clr_i)          cnt_d = '0;
    else if (wr_en && !rd_en) cnt_d = cnt_q + CW'(1);
    else if (rd_en && !wr_en) cnt_d = cnt_q - CW'(1);

    unique case (trig_i)
      2'd0:    trig_lvl = 9'd1;
      2'd1:    trig_lvl = 9'd4;
      2'd2:    trig_lvl = 9'd8;
      default: trig_lvl = 9'd14;
    endcase
    irq_d = (9'(cnt_d) >= trig_lvl);
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the count,
  // and the head output is masked while empty, so stale contents never leak.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= push_dat_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rx_irq_o <= 1'b0;
    end else begin
      if (fifo_clr_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q    <= cnt_d;
      rx_irq_o <= irq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky line-status flags: a set event wins over a coincident LSR read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      oe_o <= 1'b0;
      pe_o <= 1'b0;
      fe_o <= 1'b0;
      bi_o <= 1'b0;
    end else begin
      oe_o <= ovr                  || (oe_o && !lsr_rd_i);
      pe_o <= (push_q && push_pe_q) || (pe_o && !lsr_rd_i);
      fe_o <= (push_q && push_fe_q) || (fe_o && !lsr_rd_i);
      bi_o <= (push_q && push_bi_q) || (bi_o && !lsr_rd_i);
    end
  end

  assign dr_o       = (cnt_q != '0);
  assign rx_dat_o   = dr_o ? mem[rd_ptr_q] : 8'h00;
  assign fifo_cnt_o = cnt_q;

endmodule

// File: tb/tb_uart16550_rx.sv
// -----------------------------------------------------------------------------
// tb_uart16550_rx
//
// Directed bench for uart16550_rx. A queue-based model of the receiver's
// visible state (FIFO contents, sticky flags, interrupt level) is updated at
// character granularity; one compare process checks every DUT output against
// it on each falling edge while the model is valid, and also executes the
// hand-computed literal expectations requested by the stimulus.
// -----------------------------------------------------------------------------
module tb_uart16550_rx;

  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_n_i;
  logic             srx_i;
  logic [DIV_W-1:0] divisor_i;
  logic [1:0]       lcr_wlen_i;
  logic             lcr_pen_i;
  logic             lcr_eps_i;
  logic             fifo_clr_i;
  logic [1:0]       trig_i;
  logic             rd_i;
  logic             lsr_rd_i;
  logic [7:0]       rx_dat_o;
  logic             dr_o, oe_o, pe_o, fe_o, bi_o;
  logic [CW-1:0]    fifo_cnt_o;
  logic             rx_irq_o;

  always #5 wb_clk_i = ~wb_clk_i;

  uart16550_rx #(.RX_FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .srx_i      (srx_i),
    .divisor_i  (divisor_i),
    .lcr_wlen_i (lcr_wlen_i),
    .lcr_pen_i  (lcr_pen_i),
    .lcr_eps_i  (lcr_eps_i),
    .fifo_clr_i (fifo_clr_i),
    .trig_i     (trig_i),
    .rd_i       (rd_i),
    .lsr_rd_i   (lsr_rd_i),
    .rx_dat_o   (rx_dat_o),
    .dr_o       (dr_o),
    .oe_o       (oe_o),
    .pe_o       (pe_o),
    .fe_o       (fe_o),
    .bi_o       (bi_o),
    .fifo_cnt_o (fifo_cnt_o),
    .rx_irq_o   (rx_irq_o)
  );

  // ---------------------------------------------------------------------------
  // Model state (written by stimulus only)
  // ---------------------------------------------------------------------------
  logic [7:0] q[$];
  bit         m_oe, m_pe, m_fe, m_bi;
  int         m_lvl = 1;
  bit         check_en = 1'b0;
  int         div = 1;

  // Literal-expectation handshake to the compare process
  string      pin_name = "";
  int         pin_sel = 0;
  int         pin_exp = 0;
  bit         pin_tog = 1'b0;
  bit         pin_seen = 1'b0;

  localparam int S_DAT = 0, S_DR = 1, S_CNT = 2, S_OE = 3,
                 S_PE = 4, S_FE = 5, S_BI = 6, S_IRQ = 7;

  int tests = 0;
  int fails = 0;

  function automatic int out_val(input int sel);
    case (sel)
      S_DAT:   return int'(rx_dat_o);
      S_DR:    return int'(dr_o);
      S_CNT:   return int'(fifo_cnt_o);
      S_OE:    return int'(oe_o);
      S_PE:    return int'(pe_o);
      S_FE:    return int'(fe_o);
      S_BI:    return int'(bi_o);
      default: return int'(rx_irq_o);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge wb_clk_i) begin
    if (pin_tog != pin_seen) begin
      pin_seen = pin_tog;
      check(pin_name, out_val(pin_sel), pin_exp);
    end
    if (check_en) begin
      check("dr",     int'(dr_o),       int'(q.size() != 0));
      check("rx_dat", int'(rx_dat_o),   (q.size() != 0) ? int'(q[0]) : 0);
      check("cnt",    int'(fifo_cnt_o), q.size());
      check("oe",     int'(oe_o),       int'(m_oe));
      check("pe",     int'(pe_o),       int'(m_pe));
      check("fe",     int'(fe_o),       int'(m_fe));
      check("bi",     int'(bi_o),       int'(m_bi));
      check("irq",    int'(rx_irq_o),   int'(q.size() >= m_lvl));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic pin(input string name, input int sel, input int exp);
    pin_name = name;
    pin_sel  = sel;
    pin_exp  = exp;
    pin_tog  = ~pin_tog;
    @(negedge wb_clk_i);
    #1;
  endtask

  // Character received: apply the line-status rules to the model.
  task automatic model_char(input logic [7:0] d, input bit pen, input bit eps,
                            input bit par, input bit stop);
    bit want_xor, pe, fe, bi;
    want_xor = eps ? 1'b0 : 1'b1;
    pe = pen && ((^d ^ par) != want_xor);
    fe = !stop;
    bi = (d == 8'h00) && (!pen || !par) && !stop;
    if (q.size() == DEPTH) m_oe = 1'b1;
    else                   q.push_back(d);
    m_pe = m_pe | pe;
    m_fe = m_fe | fe;
    m_bi = m_bi | bi;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [1:0] wlen,
                            input bit pen, input bit eps, input bit perr,
                            input bit stop);
    int         nb;
    logic [7:0] d;
    bit         par;
    nb = int'(wlen) + 5;
    d  = 8'h00;
    for (int i = 0; i < nb; i++) d[i] = data[i];
    par = (eps ? ^d : ~^d) ^ perr;
    lcr_wlen_i = wlen;
    lcr_pen_i  = pen;
    lcr_eps_i  = eps;
    check_en   = 1'b0;
    srx_i = 1'b0;
    wait_cyc(16 * div);
    for (int i = 0; i < nb; i++) begin
      srx_i = d[i];
      wait_cyc(16 * div);
    end
    if (pen) begin
      srx_i = par;
      wait_cyc(16 * div);
    end
    srx_i = stop;
    wait_cyc(16 * div);
    srx_i = 1'b1;
    wait_cyc(6);
    model_char(d, pen, eps, par, stop);
    check_en = 1'b1;
    wait_cyc(4);
  endtask

  task automatic do_read();
    check_en = 1'b0;
    rd_i = 1'b1;
    if (q.size() != 0) void'(q.pop_front());
    wait_cyc(1);
    rd_i = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic do_lsr_read();
    check_en = 1'b0;
    lsr_rd_i = 1'b1;
    m_oe = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_bi = 1'b0;
    wait_cyc(1);
    lsr_rd_i = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic do_clr();
    check_en = 1'b0;
    fifo_clr_i = 1'b1;
    q.delete();
    wait_cyc(1);
    fifo_clr_i = 1'b0;
    check_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    wb_rst_n_i = 1'b0;
    srx_i      = 1'b1;
    divisor_i  = DIV_W'(1);
    lcr_wlen_i = 2'd3;
    lcr_pen_i  = 1'b0;
    lcr_eps_i  = 1'b0;
    fifo_clr_i = 1'b0;
    trig_i     = 2'd0;
    rd_i       = 1'b0;
    lsr_rd_i   = 1'b0;
    wait_cyc(3);
    pin("reset_cnt", S_CNT, 0);
    pin("reset_dr",  S_DR,  0);
    pin("reset_irq", S_IRQ, 0);
    wb_rst_n_i = 1'b1;
    wait_cyc(4);
    check_en = 1'b1;

    // 8N1, 8'hA5 at divisor 1
    send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    pin("a5_dat", S_DAT, 'hA5);
    pin("a5_dr",  S_DR,  1);
    pin("a5_cnt", S_CNT, 1);
    pin("a5_fe",  S_FE,  0);
    do_read();
    pin("a5_dr_after_rd", S_DR, 0);

    // 7E1, 8'h35: four ones, so the correct even parity bit is 0 and 1 is wrong
    send_frame(8'h35, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    pin("7e1_dat", S_DAT, 'h35);
    pin("7e1_pe",  S_PE,  1);
    do_lsr_read();
    pin("7e1_pe_cleared", S_PE, 0);
    do_read();
    send_frame(8'h35, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    pin("7e1_good_pe", S_PE, 0);
    do_read();

    // 5N1 at divisor 3: only the low five bits (0x13) are received
    div = 3;
    divisor_i = DIV_W'(3);
    send_frame(8'hF3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    pin("5n1_dat", S_DAT, 'h13);
    do_read();
    div = 1;
    divisor_i = DIV_W'(1);

    // 6O1, 8'h2A with correct parity
    send_frame(8'h2A, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    pin("6o1_pe", S_PE, 0);
    do_read();

    // framing error, non-zero data: fe without bi
    send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    pin("fe_set", S_FE, 1);
    pin("fe_bi",  S_BI, 0);
    do_read();
    do_lsr_read();

    // break: line low for 12 bit-times, then stays low a while longer
    check_en = 1'b0;
    lcr_wlen_i = 2'd3;
    lcr_pen_i  = 1'b0;
    srx_i = 1'b0;
    wait_cyc(12 * 16);
    model_char(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_en = 1'b1;
    wait_cyc(32);
    pin("brk_cnt", S_CNT, 1);
    pin("brk_bi",  S_BI,  1);
    pin("brk_fe",  S_FE,  1);
    srx_i = 1'b1;
    wait_cyc(32);
    pin("brk_no_second", S_CNT, 1);
    do_read();
    do_lsr_read();

    // 4-tick low glitch: false start, nothing pushed (checked every cycle)
    srx_i = 1'b0;
    wait_cyc(4 * div);
    srx_i = 1'b1;
    wait_cyc(40);
    pin("glitch_cnt", S_CNT, 0);

    // flush keeps sticky flags; read of empty FIFO is ignored
    send_frame(8'h11, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'h22, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    do_clr();
    pin("clr_cnt", S_CNT, 0);
    pin("clr_pe",  S_PE,  1);
    do_read();
    pin("rd_empty_cnt", S_CNT, 0);
    do_lsr_read();

    // reset in the middle of a character
    send_frame(8'h77, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    lcr_pen_i = 1'b0;
    srx_i = 1'b0;
    wait_cyc(16);
    srx_i = 1'b1;
    wait_cyc(16);
    srx_i = 1'b0;
    wait_cyc(8);
    check_en = 1'b0;
    wb_rst_n_i = 1'b0;
    srx_i = 1'b1;
    q.delete();
    m_oe = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_bi = 1'b0;
    pin("rst_mid_cnt", S_CNT, 0);
    pin("rst_mid_fe",  S_FE,  0);
    pin("rst_mid_dat", S_DAT, 0);
    wb_rst_n_i = 1'b1;
    wait_cyc(8);
    check_en = 1'b1;
    send_frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    pin("after_rst_dat", S_DAT, 'hC3);
    do_read();

    // 17 characters, no reads, trigger level 14
    trig_i = 2'd3;
    m_lvl  = 14;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(8'h10 + i), 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 12) pin("irq_at_13", S_IRQ, 0);
      if (i == 13) pin("irq_at_14", S_IRQ, 1);
    end
    pin("full_cnt",  S_CNT, 16);
    pin("full_oe",   S_OE,  1);
    pin("full_head", S_DAT, 'h10);
    pin("full_irq",  S_IRQ, 1);
    for (int i = 0; i < 16; i++) do_read();
    pin("drained_irq", S_IRQ, 0);

    wait_cyc(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
